// File: rtl/flip_pkg.sv
// +----------------------------------------------------------------------------+
// | flip_pkg                                                                   |
// | Shared encodings and helpers for the frame flip buffer.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package flip_pkg;

  // Widest sample bit_reverse can handle.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    MODE_REV    = 2'b00,
    MODE_BITREV = 2'b01,
    MODE_BOTH   = 2'b10,
    MODE_PASS   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'b00,
    BANK_FILLING  = 2'b01,
    BANK_FULL     = 2'b10,
    BANK_DRAINING = 2'b11
  } bank_state_e;

  // Reverses the low w bits of v; result is returned in the low w bits.
  function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] v,
                                                   input int unsigned     w);
    logic [MAX_W-1:0] r;
    logic [MAX_W-1:0] t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        r = {r[MAX_W-2:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

  function automatic logic mode_time_rev(input mode_e m);
    return (m == MODE_REV) || (m == MODE_BOTH);
  endfunction

  function automatic logic mode_bit_rev(input mode_e m);
    return (m == MODE_BITREV) || (m == MODE_BOTH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/flip_bank_ram.sv
// +----------------------------------------------------------------------------+
// | flip_bank_ram                                                              |
// | Two-bank sample store: one synchronous write port, one async read port.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module flip_bank_ram #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 64
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic                         wbank,
  input  logic [$clog2(FRAME_LEN)-1:0] waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         rbank,
  input  logic [$clog2(FRAME_LEN)-1:0] raddr,
  output logic [DATA_W-1:0]            rdata
);

  logic [DATA_W-1:0] mem_q [2][FRAME_LEN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wbank][waddr] <= wdata;
    end
  end

  assign rdata = mem_q[rbank][raddr];

endmodule

`default_nettype wire

// File: rtl/flip_frame_buf.sv
// +----------------------------------------------------------------------------+
// | flip_frame_buf                                                             |
// | Ping-pong frame buffer replaying frames time- and/or bit-reversed.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module flip_frame_buf
  import flip_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              din_last,
  output logic              din_ready,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_last,
  input  logic              dout_ready,
  output logic              frame_err
);

  localparam int unsigned       ADDR_W  = $clog2(FRAME_LEN);
  localparam logic [ADDR_W-1:0] WP_LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);

  bank_state_e       bank_st_q [2];
  bank_state_e       bank_st_d [2];
  logic [ADDR_W:0]   len_q     [2];
  logic [ADDR_W:0]   len_d     [2];
  mode_e             mode_q    [2];
  mode_e             mode_d    [2];
  logic              wb_q, wb_d, rb_q, rb_d;
  logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              dout_last_q, dout_last_d;
  logic              frame_err_q, frame_err_d;

  logic              w_din_ready, w_wr_fire, w_wp_at_end, w_close, w_err;
  logic              w_rd_avail, w_load, w_rd_final;
  mode_e             w_rd_mode;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data, w_rd_sample;

  flip_bank_ram #(
    .DATA_W   (DATA_W),
    .FRAME_LEN(FRAME_LEN)
  ) u_ram (
    .clk  (clk),
    .we   (w_wr_fire),
    .wbank(wb_q),
    .waddr(wp_q),
    .wdata(din),
    .rbank(rb_q),
    .raddr(w_rd_addr),
    .rdata(w_rd_data)
  );

  always_comb begin
    w_din_ready = enb & ~reset &
                  ((bank_st_q[wb_q] == BANK_EMPTY) | (bank_st_q[wb_q] == BANK_FILLING));
    w_wr_fire   = din_valid & w_din_ready;
    w_wp_at_end = (wp_q == WP_LAST);
    w_close     = w_wr_fire & (din_last | w_wp_at_end);
    // Error whenever the close point and the last marker disagree.
    w_err       = w_wr_fire & (din_last ^ w_wp_at_end);

    w_rd_mode   = mode_q[rb_q];
    w_rd_avail  = (bank_st_q[rb_q] == BANK_FULL) | (bank_st_q[rb_q] == BANK_DRAINING);
    w_load      = enb & w_rd_avail & (~dout_valid_q | dout_ready);
    w_rd_final  = (({1'b0, rp_q} + LEN_ONE) == len_q[rb_q]);
    w_rd_addr   = mode_time_rev(w_rd_mode) ?
                  ADDR_W'(len_q[rb_q] - LEN_ONE - {1'b0, rp_q}) : rp_q;
    w_rd_sample = mode_bit_rev(w_rd_mode) ?
                  DATA_W'(bit_reverse(MAX_W'(w_rd_data), DATA_W)) : w_rd_data;
  end

  always_comb begin
    bank_st_d    = bank_st_q;
    len_d        = len_q;
    mode_d       = mode_q;
    wb_d         = wb_q;
    rb_d         = rb_q;
    wp_d         = wp_q;
    rp_d         = rp_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    frame_err_d  = w_err;

    if (w_wr_fire) begin
      if (bank_st_q[wb_q] == BANK_EMPTY) begin
        mode_d[wb_q] = mode_e'(mode);
      end
      if (w_close) begin
        wp_d            = '0;
        bank_st_d[wb_q] = BANK_FULL;
        len_d[wb_q]     = {1'b0, wp_q} + LEN_ONE;
        wb_d            = ~wb_q;
      end else begin
        wp_d            = wp_q + PTR_ONE;
        bank_st_d[wb_q] = BANK_FILLING;
      end
    end

    // Write and read always target different banks, so both may update here.
    if (w_load) begin
      dout_d       = w_rd_sample;
      dout_valid_d = 1'b1;
      dout_last_d  = w_rd_final;
      if (w_rd_final) begin
        bank_st_d[rb_q] = BANK_EMPTY;
        rb_d            = ~rb_q;
        rp_d            = '0;
      end else begin
        bank_st_d[rb_q] = BANK_DRAINING;
        rp_d            = rp_q + PTR_ONE;
      end
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_st_q    <= '{BANK_EMPTY, BANK_EMPTY};
      len_q        <= '{default: '0};
      mode_q       <= '{MODE_REV, MODE_REV};
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      wp_q         <= '0;
      rp_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else if (enb) begin
      bank_st_q    <= bank_st_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign din_ready  = w_din_ready;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q & enb;
  assign dout_last  = dout_last_q;
  assign frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_flip_frame_buf.sv
// +----------------------------------------------------------------------------+
// | tb_flip_frame_buf                                                          |
// | Directed self-checking bench for flip_frame_buf (DATA_W=8, FRAME_LEN=4).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_flip_frame_buf;

  logic       clk = 1'b0;
  logic       reset, enb, din_valid, din_last, din_ready;
  logic [7:0] din, dout;
  logic [1:0] mode;
  logic       dout_valid, dout_last, dout_ready, frame_err;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int err_cnt = 0;
  int stall_cnt = 0;
  logic [8:0] outq [$];
  int         cycq [$];
  logic [8:0] exp_q [$];

  flip_frame_buf #(.DATA_W(8), .FRAME_LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .enb       (enb),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .mode      (mode),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_last (dout_last),
    .dout_ready(dout_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Output beats are captured at the negedge preceding the consuming edge.
  always @(negedge clk) begin
    if (dout_valid && dout_ready) begin
      outq.push_back({dout_last, dout});
      cycq.push_back(cyc);
    end
    if (frame_err) err_cnt++;
    if (din_valid && !din_ready) stall_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic [1:0] m);
    din = d; din_last = l; mode = m; din_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (din_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    $error("FAIL send_timeout: beat %0h not accepted within 40 cycles", d);
  endtask

  task automatic idle();
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int k = 0; k < 40 && outq.size() < n; k++) tick();
    repeat (3) tick();
  endtask

  task automatic ex(input logic l, input logic [7:0] d);
    exp_q.push_back({l, d});
  endtask

  task automatic check_out(input string tag);
    logic [31:0] obs;
    check({tag, "_count"}, 32'(outq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < outq.size()) ? 32'(outq[i]) : 'x;
      check($sformatf("%s_beat%0d", tag, i), obs, 32'(exp_q[i]));
    end
    outq.delete();
    cycq.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; enb = 1'b1; din = '0; din_valid = 1'b0; din_last = 1'b0;
    mode = 2'b00; dout_ready = 1'b1;
    tick(); tick();
    check("rst_din_ready", 32'(din_ready), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_last", 32'(dout_last), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_din_ready", 32'(din_ready), 32'd1);

    // Time reverse with exact latency
    err_cnt = 0;
    send(8'h01, 1'b0, 2'b00); send(8'h02, 1'b0, 2'b00);
    send(8'h03, 1'b0, 2'b00); send(8'h04, 1'b1, 2'b00);
    idle();
    check("lat_valid_edge_t", 32'(dout_valid), 32'd0);
    tick();
    check("lat_valid_edge_t1", 32'(dout_valid), 32'd1);
    check("rev_b0", 32'({dout_last, dout}), 32'h004);
    tick(); check("rev_b1", 32'({dout_last, dout}), 32'h003);
    tick(); check("rev_b2", 32'({dout_last, dout}), 32'h002);
    tick(); check("rev_b3", 32'({dout_last, dout}), 32'h101);
    tick(); check("rev_drained", 32'(dout_valid), 32'd0);
    check("rev_err", 32'(err_cnt), 32'd0);
    outq.delete(); cycq.delete();

    // Bit reverse in order
    send(8'h01, 1'b0, 2'b01); send(8'h80, 1'b0, 2'b01);
    send(8'h0F, 1'b0, 2'b01); send(8'hA0, 1'b1, 2'b01);
    idle(); wait_out(4);
    ex(0, 8'h80); ex(0, 8'h01); ex(0, 8'hF0); ex(1, 8'h05);
    check_out("bitrev");

    // Three back-to-back frames; third frame changes mode mid-frame (ignored)
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i), i == 3, 2'b00);
    for (int i = 0; i < 4; i++) send(8'(8'h14 + i), i == 3, 2'b11);
    send(8'h18, 1'b0, 2'b10);
    for (int i = 1; i < 4; i++) send(8'(8'h18 + i), i == 3, 2'b11);
    idle();
    check("b2b_no_stall", 32'(stall_cnt), 32'd0);
    wait_out(12);
    check("b2b_contiguous", 32'(cycq.size() == 12 ? cycq[11] - cycq[0] : -1), 32'd11);
    ex(0, 8'h13); ex(0, 8'h12); ex(0, 8'h11); ex(1, 8'h10);
    ex(0, 8'h14); ex(0, 8'h15); ex(0, 8'h16); ex(1, 8'h17);
    ex(0, 8'hD8); ex(0, 8'h58); ex(0, 8'h98); ex(1, 8'h18);
    check_out("b2b");

    // Backpressure: two frames buffered blocks input
    dout_ready = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) send(8'(8'h20 + i), (i % 4) == 3, 2'b11);
    check("bp_first8_no_stall", 32'(stall_cnt), 32'd0);
    din = 8'h28; din_last = 1'b0; din_valid = 1'b1;
    #1;
    check("bp_din_ready_low", 32'(din_ready), 32'd0);
    check("bp_valid", 32'(dout_valid), 32'd1);
    check("bp_dout_first", 32'({dout_last, dout}), 32'h020);
    tick(); tick();
    check("bp_dout_held", 32'({dout_last, dout}), 32'h020);
    check("bp_din_ready_still_low", 32'(din_ready), 32'd0);
    dout_ready = 1'b1;
    for (int i = 8; i < 12; i++) send(8'(8'h20 + i), (i % 4) == 3, 2'b11);
    idle(); wait_out(12);
    for (int i = 0; i < 12; i++) ex((i % 4) == 3, 8'(8'h20 + i));
    check_out("bp");

    // Short frame
    err_cnt = 0;
    send(8'h11, 1'b0, 2'b00); send(8'h22, 1'b1, 2'b00);
    idle(); wait_out(2);
    check("short_err", 32'(err_cnt), 32'd1);
    ex(0, 8'h22); ex(1, 8'h11);
    check_out("short");

    // Over-long frame closes at FRAME_LEN; next beat opens a new frame
    err_cnt = 0;
    for (int i = 0; i < 5; i++) send(8'(8'h0A + i), 1'b0, 2'b11);
    idle(); wait_out(4);
    check("long_err", 32'(err_cnt), 32'd1);
    ex(0, 8'h0A); ex(0, 8'h0B); ex(0, 8'h0C); ex(1, 8'h0D);
    check_out("long");
    send(8'h0F, 1'b1, 2'b00);
    idle(); wait_out(2);
    check("long_tail_err", 32'(err_cnt), 32'd2);
    ex(0, 8'h0E); ex(1, 8'h0F);
    check_out("long_tail");

    // Length-1 frame
    err_cnt = 0;
    send(8'h03, 1'b1, 2'b01);
    idle(); wait_out(1);
    check("len1_err", 32'(err_cnt), 32'd1);
    ex(1, 8'hC0);
    check_out("len1");

    // Reset during a partial frame
    send(8'h55, 1'b0, 2'b00); send(8'h66, 1'b0, 2'b00);
    idle();
    reset = 1'b1;
    #1;
    check("midrst_din_ready", 32'(din_ready), 32'd0);
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    check("midrst_no_valid", 32'(dout_valid), 32'd0);
    check("midrst_no_output", 32'(outq.size()), 32'd0);
    err_cnt = 0;
    send(8'h01, 1'b0, 2'b00); send(8'h02, 1'b0, 2'b00);
    send(8'h03, 1'b0, 2'b00); send(8'h04, 1'b1, 2'b00);
    idle(); wait_out(4);
    check("midrst_err", 32'(err_cnt), 32'd0);
    ex(0, 8'h04); ex(0, 8'h03); ex(0, 8'h02); ex(1, 8'h01);
    check_out("midrst");

    // Clock-enable freeze during drain
    for (int i = 0; i < 4; i++) send(8'(8'h31 + i), i == 3, 2'b11);
    idle();
    tick();
    enb = 1'b0;
    #1;
    check("enb_valid_low", 32'(dout_valid), 32'd0);
    check("enb_din_ready_low", 32'(din_ready), 32'd0);
    tick(); tick(); tick();
    check("enb_dout_held", 32'({dout_last, dout}), 32'h031);
    enb = 1'b1;
    wait_out(4);
    ex(0, 8'h31); ex(0, 8'h32); ex(0, 8'h33); ex(1, 8'h34);
    check_out("enb");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flip_frame_buf.md
Name: flip_frame_buf

Overview:
- Parametrised successor to the fixed 8-bit flip stage in the energy-detection datapath.
- Buffers frames of up to FRAME_LEN samples and replays each frame reversed in time, bit-reversed per sample, both, or unchanged, selected per frame.
- Ping-pong banks give full 1 sample/cycle throughput.
- Valid/ready stream on both sides; sits between sample framing and the energy accumulator.

Parameters:
- DATA_W, 8, sample width in bits (>=1).
- FRAME_LEN, 64, maximum samples per frame (>=2).
- ADDR_W, clog2(FRAME_LEN), derived localparam; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enb  in  1  clock enable; 0 freezes all state.
- din  in  DATA_W  input sample.
- din_valid  in  1  input beat valid.
- din_last  in  1  marks final sample of a frame.
- din_ready  out  1  block accepts a beat this cycle.
- mode  in  2  00 time-reverse, 01 bit-reverse in order, 10 both, 11 pass-through; sampled on the first beat of each frame.
- dout  out  DATA_W  output sample (registered).
- dout_valid  out  1  output beat valid.
- dout_last  out  1  final sample of output frame.
- dout_ready  in  1  downstream accepts.
- frame_err  out  1  one-cycle pulse on a short or over-long frame.

Behaviour:
- Reset, sync active-high: both banks EMPTY; write and read pointers 0; write bank 0, read bank 0.
  - dout=0, dout_valid=0, dout_last=0, frame_err=0.
  - din_ready=0 while reset=1. A partial frame in progress is discarded.
- enb=0: no register updates; din_ready and dout_valid forced 0 combinationally; dout, dout_last hold.
- Bank states: EMPTY -> FILLING (first beat accepted) -> FULL (closing beat accepted) -> DRAINING (first read) -> EMPTY (last read loaded into the output register).
- Per bank, stored with the frame: length (ADDR_W+1 bits) and mode.
- Input side:
  - din_ready = enb & ~reset & (write bank EMPTY or FILLING).
  - Transfer occurs when din_valid & din_ready.
  - Each transfer writes mem[wb][wp] and increments wp.
- Frame close:
  - din_last on a beat with wp < FRAME_LEN-1: short frame; length = wp+1; frame_err pulses the next cycle.
  - Beat with wp == FRAME_LEN-1 and din_last=0: frame closes at FRAME_LEN; frame_err pulses; the next beat starts a new frame.
  - din_last at wp == FRAME_LEN-1: normal close, no error.
  - On close: wp=0, bank goes FULL, wb toggles.
- Output side:
  - The output register loads when the read bank is FULL/DRAINING and (~dout_valid | dout_ready) with enb=1.
  - Read address is len-1-rp for modes 00/10 and rp for modes 01/11.
  - Bit reversal (dout[i] = mem[DATA_W-1-i]) is applied for modes 01/10.
  - dout_last=1 on the final sample of the frame.
  - After the final sample loads: bank goes EMPTY, rb toggles, rp=0.
- Latency: the closing input beat accepted at edge t gives dout_valid=1 after edge t+1, with the first sample on dout.
- Throughput: with dout_ready held 1 and back-to-back frames, din_ready never deasserts and output runs 1 beat/cycle.
- Backpressure: dout_valid & ~dout_ready holds dout, dout_valid, dout_last stable.
  - Two frames buffered (one FULL, one FULL/DRAINING) forces din_ready=0.
- Simultaneous events:
  - A write to bank X and a release of bank Y in the same cycle are independent.
  - A bank cannot be written until EMPTY, so no read/write collision on one bank.
- Length-1 frame (din_last on first beat): valid, frame_err=1, single output beat with dout_last=1.

Decomposition:
- Package flip_pkg:
  - mode encodings MODE_REV, MODE_BITREV, MODE_BOTH, MODE_PASS.
  - bank-state enum BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_DRAINING.
  - function bit_reverse(DATA_W).
- Sub-module flip_bank_ram: 2xFRAME_LEN x DATA_W register array, one write port, one asynchronous read port.
- Top flip_frame_buf holds pointers, bank-state FSMs, and the output register.

Test Plan (DATA_W=8, FRAME_LEN=4):
- Mode 00, beats 0x01,0x02,0x03,0x04 (last on 0x04), dout_ready=1 -> out 0x04,0x03,0x02,0x01; dout_last on 0x01; dout_valid one cycle after the closing edge; frame_err=0.
- Mode 01, beats 0x01,0x80,0x0F,0xA0 -> out 0x80,0x01,0xF0,0x05 in order.
- Three back-to-back frames, dout_ready=1 -> din_ready constantly 1, 12 contiguous output beats. Repeat with dout_ready=0 -> din_ready drops after the 8th accepted beat, dout held at the first sample.
- Mode 00, short frame 0x11,0x22 with last on 0x22 -> out 0x22,0x11 with last on 0x11; frame_err single pulse.
- Mode 11, beats 0x0A..0x0E with no din_last -> frame 1 = 0x0A..0x0D in order, frame_err pulse; 0x0E starts frame 2.
- reset mid-frame after 2 beats, and enb=0 for 3 cycles during drain -> after reset no dout_valid, new frame behaves as scenario 1; with enb=0, dout_valid=0, din_ready=0, output resumes with no lost or duplicated samples.
